display_scan_mux: RTL
=====================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, number of digits scanned (legal 2..8).
REQ-002 The block SHALL have parameter DIV_W, default 16, prescaler width (legal 4..24).
REQ-003 The block SHALL have localparam SEL_W = clog2(N_DIGITS), the digit index width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 CLK  in  1  the single clock; all state updates on its rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 H  in  1  scan enable; 0 = all digits dark and scan frozen.
REQ-008 DATA  in  4*N_DIGITS  digit codes; nibble N_DIGITS-1 (MSBs) is digit slot 0.
REQ-009 DP_IN  in  N_DIGITS  decimal-point request per digit; bit N_DIGITS-1 is slot 0.
REQ-010 BLANK  in  N_DIGITS  per-digit blank mask; bit N_DIGITS-1 is slot 0.
REQ-011 BRIGHT  in  3  brightness level; 7 = maximum, 0 = minimum.
REQ-012 AN  out  N_DIGITS  active-low digit enables, registered.
REQ-013 DIGIT  out  4  code of the selected digit, registered.
REQ-014 DP  out  1  active-low decimal point of the selected digit, registered.
REQ-015 SEL  out  SEL_W  current slot index (the internal slot counter).

Function
REQ-016 Prescaler PS (DIV_W bits) SHALL increment by 1 each cycle that H=1 and wrap from all-ones to 0.
REQ-017 SEL SHALL advance on the cycle PS wraps, counting 0..N_DIGITS-1 and then returning to 0; non-power-of-2 N_DIGITS SHALL never reach index N_DIGITS.
REQ-018 Slot k SHALL map to AN bit N_DIGITS-1-k, so slot 0 drives AN = 0111 for N_DIGITS=4 and slot 3 drives 1110.
REQ-019 Output registers SHALL update every cycle from the current SEL/PS/inputs: one-cycle latency from SEL/PS to AN/DIGIT/DP.
REQ-020 Lit condition: H=1, BLANK[slot]=0, PS != 0 (one-cycle anti-ghost guard at each slot start), and PS[DIV_W-1:DIV_W-3] <= BRIGHT.
REQ-021 When lit, only the selected AN bit SHALL be 0; otherwise AN SHALL be all ones.
REQ-022 DIGIT SHALL equal the selected nibble and DP SHALL equal ~DP_IN[slot] whenever H=1, independent of lit/blank.
REQ-023 When H=0, PS and SEL SHALL hold, AN SHALL be all ones next cycle, and DIGIT and DP SHALL hold; scan resumes from the held state when H returns to 1.
REQ-024 BLANK, BRIGHT, DATA and DP_IN changes SHALL take effect on the next cycle, with no effect on scan timing.
REQ-025 A blanked slot SHALL still occupy its full 2^DIV_W-cycle period.

Reset
REQ-026 With RST=1 at a clock edge: PS=0, SEL=0, AN=all ones, DIGIT=0, DP=1, regardless of H.
REQ-027 Reset asserted mid-scan SHALL take effect on the next edge; the first slot after release is slot 0 with a full period.

Verification (N_DIGITS=4, DIV_W=4 unless stated)
REQ-028 Reset: RST=1 for 2 cycles with H=1 -> AN=1111, SEL=0, DIGIT=0, DP=1.
REQ-029 Scan: H=1, BRIGHT=7, BLANK=0, DATA=16'h1234, DP_IN=4'b0010 -> each slot lasts 16 cycles with 15 cycles lit: AN 0111/DIGIT 1, 1011/2, 1101/3 with DP=0, 1110/4; then wrap to slot 0.
REQ-030 Wrap with N_DIGITS=3: SEL sequence 0,1,2,0 every 16 cycles; AN 011, 101, 110; SEL never reads 3.
REQ-031 Dimming: BRIGHT=1 -> AN active only for PS=1..3 (3 of 16 cycles); BRIGHT=0 -> PS=1 only.
REQ-032 Enable and blank: drop H at PS=5 of slot 1 -> AN=1111 next cycle, SEL=1 and PS=5 held; raise H -> resumes at PS=6. BLANK=4'b0100 -> slot 1 dark for its full period, and DIGIT still 2.
REQ-033 Reset mid-operation: RST pulsed for 1 cycle during slot 2 -> next cycle SEL=0, AN=1111; then slot 0 for a full 16 cycles.

Source files
------------

// File: rtl/display_scan_mux.sv
// Multiplexed 7-segment digit scanner.
// A free-running prescaler sets each digit's dwell time. The slot counter
// advances whenever the prescaler wraps. The digit-enable, code and decimal-point
// outputs are registered one cycle behind the counters. Brightness is set by
// gating the enable with the top three prescaler bits.
module display_scan_mux #(
  parameter  int N_DIGITS = 4,
  parameter  int DIV_W    = 16,
  localparam int SEL_W    = $clog2(N_DIGITS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  H,
  input  logic [4*N_DIGITS-1:0] DATA,
  input  logic [N_DIGITS-1:0]   DP_IN,
  input  logic [N_DIGITS-1:0]   BLANK,
  input  logic [2:0]            BRIGHT,
  output logic [N_DIGITS-1:0]   AN,
  output logic [3:0]            DIGIT,
  output logic                  DP,
  output logic [SEL_W-1:0]      SEL
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_DIGITS - 1);

  logic [DIV_W-1:0]    ps;
  logic [SEL_W-1:0]    sel;
  logic                wrap;
  logic                lit;

  // Slot-ordered views of the MSB-first input vectors
  logic [3:0]          nib_slot [N_DIGITS];
  logic [N_DIGITS-1:0] an_slot  [N_DIGITS];
  logic [N_DIGITS-1:0] dp_slot;
  logic [N_DIGITS-1:0] blank_slot;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_slot
    assign nib_slot[k]   = DATA[4*(N_DIGITS-1-k) +: 4];
    assign an_slot[k]    = ~(N_DIGITS'(1) << (N_DIGITS-1-k));
    assign dp_slot[k]    = DP_IN[N_DIGITS-1-k];
    assign blank_slot[k] = BLANK[N_DIGITS-1-k];
  end

  assign SEL  = sel;
  assign wrap = (ps == '1);

  // Prescaler and slot counter; both freeze while H is low
  always_ff @(posedge CLK) begin
    if (RST) begin
      ps  <= '0;
      sel <= '0;
    end else if (H) begin
      ps <= ps + 1'b1;
      if (wrap) begin
        sel <= (sel == LAST_SLOT) ? '0 : sel + 1'b1;
      end
    end
  end

  // Lit decision: PS==0 is a dark guard cycle at each slot start, and the top PS bits set the dimming
  always_comb begin
    lit = 1'b0;
    if (H && !blank_slot[sel] && (ps != '0) && (ps[DIV_W-1 -: 3] <= BRIGHT)) begin
      lit = 1'b1;
    end
  end

  // Registered display outputs, one cycle behind the counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      AN    <= '1;
      DIGIT <= '0;
      DP    <= 1'b1;
    end else if (H) begin
      AN    <= lit ? an_slot[sel] : '1;
      DIGIT <= nib_slot[sel];
      DP    <= ~dp_slot[sel];
    end else begin
      AN    <= '1;
    end
  end

endmodule
